// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared constants and types for the segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // One 7-segment-plus-dp code, bit7=a ... bit1=g, bit0=dp, active-high.
  typedef logic [7:0] seg_code_t;

  localparam seg_code_t SEG_BLANK = 8'h00;
  localparam seg_code_t SEG_ZERO  = 8'hfc;

  // Each digit slot is a blank (anti-ghosting) phase followed by a drive phase.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_scan_drv_scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : scan_tick_gen
// Brief    : Per-slot cycle counter for the segment scan driver. Counts
//            0..SCAN_DIV-1 and flags the last blank cycle and the last cycle
//            of the slot.
// Revision : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end_o,
  output logic blank_end_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign slot_end_o  = (cnt_q == CW'(SCAN_DIV - 1));
  assign blank_end_o = (cnt_q == CW'(BLANK_CYC - 1));

  // Next count: wrap to zero at the end of the slot.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (slot_end_o) begin
      cnt_d = '0;
    end
  end

  // Slot counter register; reset restarts the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_drv.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_drv
// Brief    : Time-multiplexes packed per-digit segment codes onto one shared
//            segment bus with active-low one-hot digit enables. Each slot
//            starts with a blank gap; new codes take effect on frame
//            boundaries only.
// Options  : SEG_SCAN_LZB_EN - leading-zero blanking applied when the
//            display shadow is loaded (digit 0 is never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] code_in,
  input  logic                    code_vld,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic                              slot_end;
  logic                              blank_end;

  logic [8*NUM_DIGITS-1:0]           pending_q;
  logic                              pend_flag_q;
  seg_code_t [NUM_DIGITS-1:0]        shadow_q;
  logic [8*NUM_DIGITS-1:0]           load_val;

  scan_state_t                       state_q;
  scan_state_t                       state_d;
  logic [IW-1:0]                     idx_q;
  logic [IW-1:0]                     idx_d;
  logic                              slot_first_q;

  logic [7:0]                        seg_q;
  logic [7:0]                        seg_d;
  logic [NUM_DIGITS-1:0]             dig_n_q;
  logic [NUM_DIGITS-1:0]             dig_n_d;
  logic                              frame_start_q;
  logic                              frame_start_d;

  scan_tick_gen #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .slot_end_o  (slot_end),
    .blank_end_o (blank_end)
  );

`ifdef SEG_SCAN_LZB_EN
  // Blank leading zero digits from the MSD down, stopping at the first
  // non-zero digit; digit 0 always keeps its code.
  function automatic logic [8*NUM_DIGITS-1:0] lzb(input logic [8*NUM_DIGITS-1:0] c);
    logic lead;
    lzb  = c;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && (c[8*i +: 8] == SEG_ZERO)) begin
        lzb[8*i +: 8] = SEG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  endfunction

  assign load_val = lzb(pending_q);
`else
  assign load_val = pending_q;
`endif

  // Capture strobes into pending; move pending to the shadow at the frame
  // boundary (the cycle frame_start is high). A strobe in that same cycle
  // lands in pending and waits for the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      shadow_q    <= '0;
    end else begin
      if (frame_start_q && pend_flag_q) begin
        shadow_q    <= load_val;
        pend_flag_q <= 1'b0;
      end
      if (code_vld) begin
        pending_q   <= code_in;
        pend_flag_q <= 1'b1;
      end
    end
  end

  // Slot FSM next state: blank gap, then drive, then advance the digit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      BLANK: begin
        if (blank_end) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (slot_end) begin
          state_d = BLANK;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // FSM state, digit index and first-cycle-of-slot marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      slot_first_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      slot_first_q <= slot_end;
    end
  end

  // Output decode from the current slot state; registered below so the
  // ports are driven purely from flops.
  always_comb begin
    seg_d         = SEG_BLANK;
    dig_n_d       = '1;
    frame_start_d = 1'b0;
    if (state_q == DRIVE) begin
      seg_d          = shadow_q[idx_q];
      dig_n_d[idx_q] = 1'b0;
    end
    if ((state_q == BLANK) && slot_first_q && (idx_q == '0)) begin
      frame_start_d = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q         <= SEG_BLANK;
      dig_n_q       <= '1;
      frame_start_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dig_n_q       <= dig_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dig_n       = dig_n_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_drv.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_drv
// Brief    : Self-checking bench for seg_scan_drv (3 digits, 8-cycle slots,
//            2-cycle blank gap) against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_drv;

  localparam int ND    = 3;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * DIV;

  logic            clk;
  logic            rst;
  logic [8*ND-1:0] code_in;
  logic            code_vld;
  logic [7:0]      seg;
  logic [ND-1:0]   dig_n;
  logic            frame_start;

  int checks;
  int failures;

  // Reference model: cycle number since the frame_start that follows reset.
  bit              m_rst;
  int              m_n;
  logic [8*ND-1:0] m_shadow;
  logic [8*ND-1:0] m_pend;
  bit              m_flag;

  seg_scan_drv #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (DIV),
    .BLANK_CYC  (BLK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .code_in     (code_in),
    .code_vld    (code_vld),
    .seg         (seg),
    .dig_n       (dig_n),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, m_n, obs, exp_v);
    end
  endtask

  // What the display should hold after a load of code c.
  function automatic logic [8*ND-1:0] disp_of(input logic [8*ND-1:0] c);
    logic [8*ND-1:0] r;
    r = c;
`ifdef SEG_SCAN_LZB_EN
    for (int i = ND - 1; i >= 1; i--) begin
      if (c[8*i +: 8] != 8'hfc) break;
      r[8*i +: 8] = 8'h00;
    end
`endif
    return r;
  endfunction

  // Check outputs of the current cycle, apply inputs, advance one clock.
  // Called with the simulator sitting just after a falling edge.
  task automatic step(input logic r, input logic v, input logic [8*ND-1:0] c);
    logic [7:0]    e_seg;
    logic [ND-1:0] e_dig;
    logic          e_fs;
    int            off;
    int            d;
    e_seg = 8'h00;
    e_dig = '1;
    e_fs  = 1'b0;
    if (!m_rst) begin
      off  = m_n % DIV;
      d    = (m_n / DIV) % ND;
      e_fs = ((m_n % FRAME) == 0);
      if (off >= BLK) begin
        e_seg    = m_shadow[8*d +: 8];
        e_dig[d] = 1'b0;
      end
    end
    chk("seg", {24'd0, seg}, {24'd0, e_seg});
    chk("dig_n", {29'd0, dig_n}, {29'd0, e_dig});
    chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    rst      = r;
    code_vld = v;
    code_in  = c;
    @(posedge clk);
    if (r) begin
      m_rst    = 1'b1;
      m_shadow = '0;
      m_pend   = '0;
      m_flag   = 1'b0;
    end else begin
      if (!m_rst && ((m_n % FRAME) == 0) && m_flag) begin
        m_shadow = disp_of(m_pend);
        m_flag   = 1'b0;
      end
      if (v) begin
        m_pend = c;
        m_flag = 1'b1;
      end
      if (m_rst) begin
        m_rst = 1'b0;
        m_n   = 0;
      end else begin
        m_n++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, '0);
  endtask

  // Idle until the model is at the given offset within a frame.
  task automatic align(input int pos);
    for (int i = 0; i < FRAME && (m_n % FRAME) != pos; i++) step(1'b0, 1'b0, '0);
  endtask

  function automatic logic [8*ND-1:0] rnd_code();
    logic [8*ND-1:0] c;
    for (int i = 0; i < ND; i++) begin
      c[8*i +: 8] = ($urandom_range(0, 2) == 0) ? 8'hfc : 8'($urandom);
    end
    return c;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    m_rst    = 1'b1;
    m_n      = 0;
    m_shadow = '0;
    m_pend   = '0;
    m_flag   = 1'b0;
    rst      = 1'b1;
    code_vld = 1'b0;
    code_in  = '0;
    @(posedge clk);
    @(negedge clk);
    // Reset state, then idle two frames.
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(49);
    // Single strobe mid-frame.
    align(9);
    step(1'b0, 1'b1, 24'hda60fc);
    idle(2 * FRAME);
    // Two strobes in one frame: the last one wins.
    align(4);
    step(1'b0, 1'b1, 24'h606060);
    idle(5);
    step(1'b0, 1'b1, 24'hf2f2f2);
    idle(2 * FRAME);
    // Strobe in the frame_start cycle: applies one frame later.
    align(0);
    step(1'b0, 1'b1, 24'hb6b6b6);
    idle(2 * FRAME);
    // Strobe in the last cycle before a frame boundary.
    align(FRAME - 1);
    step(1'b0, 1'b1, 24'h9e9e9e);
    idle(FRAME + 4);
    // Reset during digit 1 drive.
    align(13);
    step(1'b1, 1'b0, '0);
    idle(2 * FRAME);
    // Leading-zero patterns.
    align(6);
    step(1'b0, 1'b1, 24'hfcfc60);
    idle(2 * FRAME);
    align(6);
    step(1'b0, 1'b1, 24'hfcfcfc);
    idle(2 * FRAME);
    align(6);
    step(1'b0, 1'b1, 24'hfc60fc);
    idle(2 * FRAME);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 11) == 0), rnd_code());
    end
    idle(2 * FRAME);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
